pipeline_hazard_ctrl: RTL

//  Stall/flush controller for the deep pipeline (IF-ID-EX-MR-MW-WB).
//  - Sits beside the forwarding unit and consumes the same stage tags.
//  - Inserts a bubble for load-use cases that MR->EX forwarding cannot cover.
//  - Freezes the pipe while the MR-stage data memory is busy, and flushes IF/ID and ID/EX on a taken branch.
//  - Counts stall cycles and raises a sticky error on a memory timeout.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the IF-ID-EX-MR-MW-WB pipeline control blocks.
// State codes and the hardwired-zero register index.
package pipe_pkg;

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
   localparam logic [1:0] ST_FLUSH      = 2'd3;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      S_RUN        = ST_RUN,
      S_LOAD_STALL = ST_LOAD_STALL,
      S_MEM_WAIT   = ST_MEM_WAIT,
      S_FLUSH      = ST_FLUSH
   } hz_state_e;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, data-memory wait freeze, taken-branch flush,
// a saturating stall-cycle counter and a sticky memory-timeout error.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       PR_ID_Rs,
   input  logic [4:0]       PR_ID_Rt,
   input  logic             PR_ID_UsesRt,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             EX_MR_MemRead,
   input  logic             mem_ready,
   input  logic             EX_BranchTaken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_timeout_err
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

   hz_state_e         state_q, state_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wait_cnt;
   logic              load_use;
   logic              timeout_hit;

   assign load_use = ID_EX_MemRead && (ID_EX_Rd != REG_ZERO) &&
                     ((ID_EX_Rd == PR_ID_Rs) || (PR_ID_UsesRt && (ID_EX_Rd == PR_ID_Rt)));

   assign timeout_hit = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   // NOTE: every output and next-state signal gets a default first, so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (EX_MR_MemRead && !mem_ready) begin
               state_d     = S_MEM_WAIT;
               pipe_hold   = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
            end else if (EX_BranchTaken) begin
               state_d      = S_FLUSH;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (load_use) begin
               state_d      = S_LOAD_STALL;
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         // Once timed out the pipe stays frozen until reset, even if data finally arrives.
         S_MEM_WAIT: begin
            if (mem_ready && !err_q) begin
               state_d = S_RUN;
            end else begin
               pipe_hold   = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               if (!mem_ready && timeout_hit) begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD_STALL, S_FLUSH: state_d = S_RUN;
         default:               state_d = S_RUN;
      endcase

      if (reset) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
         pipe_hold    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RUN;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // wait_cnt is zero on entry to MEM_WAIT and counts each cycle spent there.
   sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (state_d != S_MEM_WAIT),
      .inc_i   (state_q == S_MEM_WAIT),
      .count_o (wait_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (1'b0),
      .inc_i   (!pc_write),
      .count_o (stall_cycles)
   );

   assign mem_timeout_err = err_q;

endmodule : pipeline_hazard_ctrl
